// File: rtl/sysbus_arb_pkg.sv
// Shared types and helpers for the system-bus arbiter.
package sysbus_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } arb_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sysbus_arbiter_if.sv
// Channel-side and memory-side signals of the system-bus arbiter.
interface sysbus_arbiter_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  import sysbus_arb_pkg::*;

  localparam int unsigned ID_W = id_width(NUM_CH);

  logic [NUM_CH-1:0]        ch_strobe;
  logic [NUM_CH-1:0]        ch_rw;
  logic [NUM_CH*ADDR_W-1:0] ch_address;
  logic [NUM_CH*DATA_W-1:0] ch_data_in;
  logic [DATA_W-1:0]        ch_data_out;
  logic [NUM_CH-1:0]        ch_ready;
  logic                     mem_strobe;
  logic                     mem_rw;
  logic [ADDR_W-1:0]        mem_address;
  logic [DATA_W-1:0]        mem_data_in;
  logic [DATA_W-1:0]        mem_data_out;
  logic                     mem_ready;
  logic [ID_W-1:0]          grant_id;
  logic                     busy;
  logic                     timeout_err;

  // Arbiter view: serves the channels, masters the memory.
  modport master (
    input  ch_strobe, ch_rw, ch_address, ch_data_in, mem_data_out, mem_ready,
    output ch_data_out, ch_ready, mem_strobe, mem_rw, mem_address, mem_data_in,
    output grant_id, busy, timeout_err
  );

  // Environment view: channels and memory model.
  modport slave (
    output ch_strobe, ch_rw, ch_address, ch_data_in, mem_data_out, mem_ready,
    input  ch_data_out, ch_ready, mem_strobe, mem_rw, mem_address, mem_data_in,
    input  grant_id, busy, timeout_err
  );

endinterface

// File: rtl/sysbus_arb_pick.sv
// Combinational picker: first requesting channel at or after start_i, wrapping at NUM_CH.
module sysbus_arb_pick #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ID_W   = 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [ID_W-1:0]   start_i,
  output logic [ID_W-1:0]   idx_o,
  output logic              valid_o
);

  logic [NUM_CH-1:0] rot;

  // Rotate so that bit 0 is the channel at start_i.
  assign rot = NUM_CH'({req_i, req_i} >> start_i);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!valid_o && rot[i]) begin
        valid_o = 1'b1;
        idx_o   = ID_W'((32'(start_i) + i) % NUM_CH);
      end
    end
  end

endmodule

// File: rtl/sysbus_arbiter.sv
// N-channel arbiter onto one registered memory port with response watchdog.
// Define SYSBUS_ARB_RR_EN for round-robin; default is fixed priority, channel 0 highest.
module sysbus_arbiter
  import sysbus_arb_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic              clock,
  input logic              reset,
  sysbus_arbiter_if.master bus
);

  localparam int unsigned ID_W = id_width(NUM_CH);
  localparam int unsigned WD_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  arb_state_e        state_q, state_d;
  logic              mem_strobe_q, mem_strobe_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
  logic [NUM_CH-1:0] ch_ready_q, ch_ready_d;
  logic [DATA_W-1:0] ch_data_out_q, ch_data_out_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic [ID_W-1:0]   start;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_valid;
  logic              sel_rw;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

`ifdef SYSBUS_ARB_RR_EN
  logic [ID_W-1:0] ptr_q;

  // Search begins one past the last winner; reset value makes channel 0 first.
  assign start = (ptr_q == ID_W'(NUM_CH - 1)) ? '0 : ptr_q + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= ID_W'(NUM_CH - 1);
    end else if (state_q == StIdle && pick_valid) begin
      ptr_q <= pick_idx;
    end
  end
`else
  assign start = '0;
`endif

  sysbus_arb_pick #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_pick (
    .req_i   (bus.ch_strobe),
    .start_i (start),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    sel_rw   = RW_READ;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (pick_idx == ID_W'(i)) begin
        sel_rw   = bus.ch_rw[i];
        sel_addr = bus.ch_address[i*ADDR_W +: ADDR_W];
        sel_data = bus.ch_data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_strobe_d  = mem_strobe_q;
    mem_rw_d      = mem_rw_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    ch_ready_d    = '0;
    ch_data_out_d = '0;
    grant_d       = grant_q;
    timeout_d     = timeout_q;
    wd_d          = wd_q;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d       = StBusy;
          mem_strobe_d  = 1'b1;
          mem_rw_d      = sel_rw;
          mem_address_d = sel_addr;
          mem_data_in_d = sel_data;
          grant_d       = pick_idx;
          wd_d          = '0;
        end
      end
      StBusy: begin
        wd_d = wd_q + 1'b1;
        if (bus.mem_ready || (TIMEOUT_CYC != 0 && wd_q == WD_W'(TIMEOUT_CYC - 1))) begin
          state_d      = StResp;
          mem_strobe_d = 1'b0;
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_ready_d[i] = (grant_q == ID_W'(i));
          end
          // mem_ready takes precedence over an expiry in the same cycle.
          if (bus.mem_ready) begin
            ch_data_out_d = (mem_rw_q == RW_WRITE) ? '0 : bus.mem_data_out;
          end else begin
            timeout_d = 1'b1;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      mem_strobe_q  <= 1'b0;
      mem_rw_q      <= RW_READ;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      ch_ready_q    <= '0;
      ch_data_out_q <= '0;
      grant_q       <= '0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      mem_strobe_q  <= mem_strobe_d;
      mem_rw_q      <= mem_rw_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      ch_ready_q    <= ch_ready_d;
      ch_data_out_q <= ch_data_out_d;
      grant_q       <= grant_d;
      busy_q        <= busy_d;
      timeout_q     <= timeout_d;
      wd_q          <= wd_d;
    end
  end

  assign bus.mem_strobe  = mem_strobe_q;
  assign bus.mem_rw      = mem_rw_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_data_in = mem_data_in_q;
  assign bus.ch_ready    = ch_ready_q;
  assign bus.ch_data_out = ch_data_out_q;
  assign bus.grant_id    = grant_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Bench for sysbus_arbiter: directed scenarios plus random traffic against a transaction model.
module tb_sysbus_arbiter;
  import sysbus_arb_pkg::*;

  localparam int unsigned NUM_CH      = 3;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned TIMEOUT_CYC = 4;
`ifdef SYSBUS_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sysbus_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sysbus_arbiter #(
    .NUM_CH      (NUM_CH),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Transaction-level reference: who owns memory, what was latched, what is being returned.
  bit                m_open, m_resp, m_to;
  int                m_grant, m_ptr, m_cnt;
  logic              m_rw;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  logic [NUM_CH-1:0] exp_rdy;

  function automatic int ref_pick(input logic [NUM_CH-1:0] req, input int ptr);
    int first;
    first = RR_EN ? (ptr + 1) % NUM_CH : 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req[(first + i) % NUM_CH]) return (first + i) % NUM_CH;
    end
    return 0;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_open  <= 1'b0;
      m_resp  <= 1'b0;
      m_to    <= 1'b0;
      m_grant <= 0;
      m_ptr   <= NUM_CH - 1;
      m_cnt   <= 0;
      m_rw    <= 1'b1;
      m_addr  <= '0;
      m_wdata <= '0;
      m_rdata <= '0;
    end else if (m_resp) begin
      m_resp <= 1'b0;
    end else if (m_open) begin
      m_cnt <= m_cnt + 1;
      if (bus.mem_ready) begin
        m_open  <= 1'b0;
        m_resp  <= 1'b1;
        m_rdata <= m_rw ? bus.mem_data_out : '0;
      end else if (TIMEOUT_CYC != 0 && m_cnt + 1 == int'(TIMEOUT_CYC)) begin
        m_open  <= 1'b0;
        m_resp  <= 1'b1;
        m_rdata <= '0;
        m_to    <= 1'b1;
      end
    end else if (bus.ch_strobe != '0) begin
      m_grant <= ref_pick(bus.ch_strobe, m_ptr);
      m_ptr   <= ref_pick(bus.ch_strobe, m_ptr);
      m_rw    <= bus.ch_rw[ref_pick(bus.ch_strobe, m_ptr)];
      m_addr  <= bus.ch_address[ref_pick(bus.ch_strobe, m_ptr)*ADDR_W +: ADDR_W];
      m_wdata <= bus.ch_data_in[ref_pick(bus.ch_strobe, m_ptr)*DATA_W +: DATA_W];
      m_open  <= 1'b1;
      m_cnt   <= 0;
    end
  end

  always_comb begin
    exp_rdy = '0;
    if (m_resp) exp_rdy[m_grant] = 1'b1;
  end

  always @(negedge clock) begin
    if (!reset) begin
      chk("mdl_mem_strobe", 64'(bus.mem_strobe), 64'(m_open));
      chk("mdl_mem_rw", 64'(bus.mem_rw), 64'(m_rw));
      chk("mdl_mem_address", 64'(bus.mem_address), 64'(m_addr));
      chk("mdl_mem_data_in", 64'(bus.mem_data_in), 64'(m_wdata));
      chk("mdl_ch_ready", 64'(bus.ch_ready), 64'(exp_rdy));
      chk("mdl_grant_id", 64'(bus.grant_id), 64'(m_grant));
      chk("mdl_busy", 64'(bus.busy), 64'(m_open || m_resp));
      chk("mdl_timeout_err", 64'(bus.timeout_err), 64'(m_to));
      if (m_resp) chk("mdl_ch_data_out", 64'(bus.ch_data_out), 64'(m_rdata));
    end
  end

  task automatic set_ch(input int i, input logic rw, input logic [31:0] addr,
                        input logic [31:0] data);
    bus.ch_rw[i]                        = rw;
    bus.ch_address[i*ADDR_W +: ADDR_W]  = addr;
    bus.ch_data_in[i*DATA_W +: DATA_W]  = data;
  endtask

  task automatic clr_inputs();
    bus.ch_strobe    = '0;
    bus.ch_rw        = '0;
    bus.ch_address   = '0;
    bus.ch_data_in   = '0;
    bus.mem_ready    = 1'b0;
    bus.mem_data_out = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    clr_inputs();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Bounded wait for any ready pulse; idx is -1 if none arrives.
  task automatic wait_rdy(input string name, output int idx);
    idx = -1;
    for (int n = 0; n < 40 && idx < 0; n++) begin
      @(negedge clock);
      for (int i = 0; i < NUM_CH; i++) if (bus.ch_ready[i]) idx = i;
    end
    vectors++;
    if (idx < 0) begin
      miscompares++;
      $display("FAIL %s: got no ch_ready, expected a pulse within 40 cycles", name);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    int idx, n;
    int order[4];
    int exp_order[4];
    bit pend[NUM_CH];

    clr_inputs();
    repeat (2) @(negedge clock);
    chk("rst_mem_strobe", 64'(bus.mem_strobe), 0);
    chk("rst_mem_rw", 64'(bus.mem_rw), 1);
    chk("rst_mem_address", 64'(bus.mem_address), 0);
    chk("rst_mem_data_in", 64'(bus.mem_data_in), 0);
    chk("rst_ch_ready", 64'(bus.ch_ready), 0);
    chk("rst_ch_data_out", 64'(bus.ch_data_out), 0);
    chk("rst_grant_id", 64'(bus.grant_id), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_timeout_err", 64'(bus.timeout_err), 0);
    reset = 1'b0;

    // Single read: ch1 reads 0x100, mem_ready in the third BUSY cycle.
    @(negedge clock);
    set_ch(1, 1'b1, 32'h100, 32'h0);
    bus.ch_strobe    = 3'b010;
    bus.mem_data_out = 32'h5555_0000;
    @(negedge clock);
    chk("rd_mem_strobe", 64'(bus.mem_strobe), 1);
    chk("rd_grant_id", 64'(bus.grant_id), 1);
    chk("rd_mem_address", 64'(bus.mem_address), 64'h100);
    @(negedge clock);
    @(negedge clock);
    bus.mem_ready    = 1'b1;
    bus.mem_data_out = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("rd_ch_ready", 64'(bus.ch_ready), 64'b010);
    chk("rd_ch_data_out", 64'(bus.ch_data_out), 64'hDEAD_BEEF);
    chk("rd_strobe_dropped", 64'(bus.mem_strobe), 0);
    bus.ch_strobe = '0;
    bus.mem_ready = 1'b0;
    @(negedge clock);
    chk("rd_single_pulse", 64'(bus.ch_ready), 0);
    chk("rd_idle", 64'(bus.busy), 0);

    // Simultaneous ch0/ch1 requests held for four transactions.
    do_reset();
    set_ch(0, 1'b1, 32'h10, 32'h0);
    set_ch(1, 1'b1, 32'h20, 32'h0);
    bus.ch_strobe    = 3'b011;
    bus.mem_ready    = 1'b1;
    bus.mem_data_out = $urandom;
    exp_order = '{0, RR_EN ? 1 : 0, 0, RR_EN ? 1 : 0};
    for (int t = 0; t < 4; t++) begin
      wait_rdy("sim_wait", idx);
      order[t] = idx;
      chk($sformatf("sim_order_%0d", t), 64'(order[t]), 64'(exp_order[t]));
    end
    bus.ch_strobe = '0;
    bus.mem_ready = 1'b0;
    repeat (3) @(negedge clock);

    // Write with churn on ch0 fields while BUSY.
    set_ch(0, 1'b0, 32'h40, 32'h1234_5678);
    bus.ch_strobe    = 3'b001;
    bus.mem_data_out = 32'hAAAA_5555;
    @(negedge clock);
    for (int b = 0; b < 3; b++) begin
      chk("wr_mem_strobe", 64'(bus.mem_strobe), 1);
      chk("wr_mem_rw", 64'(bus.mem_rw), 0);
      chk("wr_mem_address", 64'(bus.mem_address), 64'h40);
      chk("wr_mem_data_in", 64'(bus.mem_data_in), 64'h1234_5678);
      set_ch(0, 1'b1, 32'hFFFF_0000 + 32'(b), $urandom);
      if (b == 2) bus.mem_ready = 1'b1;
      @(negedge clock);
    end
    chk("wr_ch_ready", 64'(bus.ch_ready), 64'b001);
    chk("wr_ch_data_out", 64'(bus.ch_data_out), 0);
    bus.ch_strobe = '0;
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clock);

    // Watchdog expiry: no mem_ready at all.
    do_reset();
    set_ch(2, 1'b1, 32'h200, 32'h0);
    bus.ch_strobe    = 3'b100;
    bus.mem_data_out = 32'hCAFE_0000;
    n   = 0;
    idx = 0;
    for (int c = 0; c < 20 && idx == 0; c++) begin
      @(negedge clock);
      if (bus.mem_strobe) n++;
      if (bus.ch_ready != '0) idx = 1;
    end
    chk("wd_strobe_cycles", 64'(n), 4);
    chk("wd_ch_ready", 64'(bus.ch_ready), 64'b100);
    chk("wd_ch_data_out", 64'(bus.ch_data_out), 0);
    chk("wd_timeout_err", 64'(bus.timeout_err), 1);
    bus.ch_strobe = '0;
    @(negedge clock);
    set_ch(0, 1'b1, 32'h300, 32'h0);
    bus.ch_strobe = 3'b001;
    bus.mem_ready = 1'b1;
    wait_rdy("wd_next_wait", idx);
    chk("wd_sticky", 64'(bus.timeout_err), 1);
    bus.ch_strobe = '0;
    bus.mem_ready = 1'b0;

    // mem_ready on the expiry cycle wins.
    do_reset();
    chk("wd_cleared", 64'(bus.timeout_err), 0);
    set_ch(2, 1'b1, 32'h204, 32'h0);
    bus.ch_strobe    = 3'b100;
    bus.mem_data_out = 32'hCAFE_0001;
    repeat (4) @(negedge clock);
    bus.mem_ready = 1'b1;
    @(negedge clock);
    chk("race_ch_ready", 64'(bus.ch_ready), 64'b100);
    chk("race_ch_data_out", 64'(bus.ch_data_out), 64'hCAFE_0001);
    chk("race_timeout_err", 64'(bus.timeout_err), 0);
    bus.ch_strobe = '0;
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clock);

    // Reset in the middle of a ch1 read.
    set_ch(1, 1'b1, 32'h100, 32'h0);
    bus.ch_strobe = 3'b010;
    repeat (2) @(negedge clock);
    chk("mid_pre_grant", 64'(bus.grant_id), 1);
    chk("mid_pre_address", 64'(bus.mem_address), 64'h100);
    #2 reset = 1'b1;
    #1;
    chk("mid_mem_strobe", 64'(bus.mem_strobe), 0);
    chk("mid_busy", 64'(bus.busy), 0);
    chk("mid_grant_id", 64'(bus.grant_id), 0);
    chk("mid_mem_address", 64'(bus.mem_address), 0);
    chk("mid_mem_rw", 64'(bus.mem_rw), 1);
    chk("mid_ch_ready", 64'(bus.ch_ready), 0);
    @(negedge clock);
    @(negedge clock);
    reset            = 1'b0;
    bus.mem_ready    = 1'b1;
    bus.mem_data_out = 32'h0BAD_F00D;
    wait_rdy("mid_next_wait", idx);
    chk("mid_next_grant", 64'(idx), 1);
    chk("mid_next_data", 64'(bus.ch_data_out), 64'h0BAD_F00D);
    bus.ch_strobe = '0;
    bus.mem_ready = 1'b0;

    // Random traffic; channels hold strobe until served, fields churn freely.
    do_reset();
    for (int i = 0; i < NUM_CH; i++) pend[i] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      for (int i = 0; i < NUM_CH; i++) begin
        if (pend[i] && bus.ch_ready[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          set_ch(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end else if (pend[i] && $urandom_range(0, 3) == 0) begin
          set_ch(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
        bus.ch_strobe[i] = pend[i];
      end
      bus.mem_ready    = ($urandom_range(0, 1) == 1);
      bus.mem_data_out = $urandom;
    end
    clr_inputs();
    repeat (3) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
